// File: rtl/cpu_defs.sv
// cpu_defs: constants shared by the writeback stage and its classifier.
// Instruction-class codes, architectural register numbers, the range of
// compare-only data-processing opcodes, and the writeback FSM encoding.
package cpu_defs;

    // Instruction class field inst[27:25]
    localparam logic [2:0] CLASS_DP     = 3'b000;  // data-processing, register operand
    localparam logic [2:0] CLASS_DP_IMM = 3'b001;  // data-processing, immediate operand
    localparam logic [2:0] CLASS_LS     = 3'b010;  // single load/store
    localparam logic [2:0] CLASS_BR     = 3'b101;  // branch / branch-with-link

    // Architectural registers with special meaning
    localparam logic [3:0] REG_LR = 4'd14;
    localparam logic [3:0] REG_PC = 4'd15;

    // TST/TEQ/CMP/CMN only set flags and never write rd
    localparam logic [3:0] OPC_CMP_LO = 4'b1000;
    localparam logic [3:0] OPC_CMP_HI = 4'b1011;

    typedef enum logic {
        ST_RUN       = 1'b0,
        ST_LOAD_WAIT = 1'b1
    } wb_state_e;

    function automatic logic is_compare_op(input logic [3:0] opc);
        return (opc >= OPC_CMP_LO) && (opc <= OPC_CMP_HI);
    endfunction

endpackage

// File: rtl/wb_classify.sv
// wb_classify: pure decode of which register writes an instruction makes.
// rd_we_o covers both the immediate ALU write and the deferred load write;
// is_load_o tells the caller that the rd write waits for memory data.
module wb_classify
    import cpu_defs::*;
(
    input  logic [31:0] inst_i,
    output logic        rd_we_o,
    output logic        rn_we_o,
    output logic        is_load_o,
    output logic        link_we_o
);

    logic [2:0] cls;
    logic       unused_inst_bits;

    assign cls              = inst_i[27:25];
    assign unused_inst_bits = ^{inst_i[31:28], inst_i[19:0]};

    // Decode the write set from the class and the opcode/L/W bits
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        rd_we_o   = 1'b0;
        rn_we_o   = 1'b0;
        is_load_o = 1'b0;
        link_we_o = 1'b0;
        unique case (cls)
            CLASS_DP, CLASS_DP_IMM: rd_we_o = !is_compare_op(inst_i[24:21]);
            CLASS_LS: begin
                rn_we_o   = inst_i[21];
                rd_we_o   = inst_i[20];
                is_load_o = inst_i[20];
            end
            CLASS_BR: link_we_o = inst_i[24];
            default: ;
        endcase
    end

endmodule

// File: rtl/writeback_reg_r.sv
// writeback_reg_r: final pipeline stage producing the register-file write
// port. ALU, base-writeback and link writes appear one cycle after accept;
// loads park the stage in LOAD_WAIT (stall_o high) until mem_rvalid_i.
// Optional macro WB_PERF_EN adds retired/stall performance counters.
module writeback_reg_r
    import cpu_defs::*;
(
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        valid_i,
    input  logic        cond_pass_i,
    input  logic        flush_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_rvalid_i,
    output logic        stall_o,
    output logic        wb_en_o,
    output logic [3:0]  wb_addr_o,
    output logic [31:0] wb_data_o,
    output logic        flush_o
`ifdef WB_PERF_EN
    ,
    output logic [31:0] retired_cnt_o,
    output logic [31:0] load_stall_cnt_o
`endif
);

    wb_state_e   state_q;
    logic        wb_en_q;
    logic [3:0]  wb_addr_q;
    logic [31:0] wb_data_q;
    logic [3:0]  ld_rd_q;

    logic        rd_we;
    logic        rn_we;
    logic        is_load;
    logic        link_we;
    logic        accept;

    wb_classify u_classify (
        .inst_i    (inst_i),
        .rd_we_o   (rd_we),
        .rn_we_o   (rn_we),
        .is_load_o (is_load),
        .link_we_o (link_we)
    );

    assign stall_o = (state_q == ST_LOAD_WAIT);
    assign accept  = valid_i & cond_pass_i & !flush_i & !stall_o;

    // FSM and registered write port; each write is a single-cycle pulse
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= ST_RUN;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            ld_rd_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            wb_en_q <= 1'b0;
            unique case (state_q)
                ST_RUN: begin
                    if (accept) begin
                        if (rd_we && !is_load) begin
                            wb_en_q   <= 1'b1;
                            wb_addr_q <= inst_i[15:12];
                            wb_data_q <= alu_result_i;
                        end else if (rn_we) begin
                            wb_en_q   <= 1'b1;
                            wb_addr_q <= inst_i[19:16];
                            wb_data_q <= alu_result_i;
                        end else if (link_we) begin
                            wb_en_q   <= 1'b1;
                            wb_addr_q <= REG_LR;
                            wb_data_q <= pc_i + 32'd4;
                        end
                        if (is_load) begin
                            state_q <= ST_LOAD_WAIT;
                            ld_rd_q <= inst_i[15:12];
                        end
                    end
                end
                ST_LOAD_WAIT: begin
                    // Load data always lands after any base write, so rd wins if rd == rn
                    if (mem_rvalid_i) begin
                        wb_en_q   <= 1'b1;
                        wb_addr_q <= ld_rd_q;
                        wb_data_q <= mem_rdata_i;
                        state_q   <= ST_RUN;
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign wb_en_o   = wb_en_q;
    assign wb_addr_o = wb_addr_q;
    assign wb_data_o = wb_data_q;
    assign flush_o   = wb_en_q & (wb_addr_q == REG_PC);

`ifdef WB_PERF_EN
    logic [31:0] retired_cnt_q;
    logic [31:0] load_stall_cnt_q;

    // Retired-instruction and load-stall cycle counters, free-running wrap
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            retired_cnt_q    <= '0;
            load_stall_cnt_q <= '0;
        end else begin
            if (accept)  retired_cnt_q    <= retired_cnt_q + 32'd1;
            if (stall_o) load_stall_cnt_q <= load_stall_cnt_q + 32'd1;
        end
    end

    assign retired_cnt_o    = retired_cnt_q;
    assign load_stall_cnt_o = load_stall_cnt_q;
`else
    // Without the performance option there is no counter state at all.
`endif

endmodule

// File: tb/tb_writeback_reg_r.sv
// tb_writeback_reg_r: scoreboard bench. Tasks push expected register writes
// as they drive instructions; a negedge monitor pops one per wb_en_o pulse.
module tb_writeback_reg_r;

    logic        clk_i;
    logic        reset_n_i;
    logic        valid_i;
    logic        cond_pass_i;
    logic        flush_i;
    logic [31:0] inst_i;
    logic [31:0] pc_i;
    logic [31:0] alu_result_i;
    logic [31:0] mem_rdata_i;
    logic        mem_rvalid_i;
    logic        stall_o;
    logic        wb_en_o;
    logic [3:0]  wb_addr_o;
    logic [31:0] wb_data_o;
    logic        flush_o;
`ifdef WB_PERF_EN
    logic [31:0] retired_cnt_o;
    logic [31:0] load_stall_cnt_o;
`endif

    writeback_reg_r dut (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .valid_i      (valid_i),
        .cond_pass_i  (cond_pass_i),
        .flush_i      (flush_i),
        .inst_i       (inst_i),
        .pc_i         (pc_i),
        .alu_result_i (alu_result_i),
        .mem_rdata_i  (mem_rdata_i),
        .mem_rvalid_i (mem_rvalid_i),
        .stall_o      (stall_o),
        .wb_en_o      (wb_en_o),
        .wb_addr_o    (wb_addr_o),
        .wb_data_o    (wb_data_o),
        .flush_o      (flush_o)
`ifdef WB_PERF_EN
        ,
        .retired_cnt_o    (retired_cnt_o),
        .load_stall_cnt_o (load_stall_cnt_o)
`endif
    );

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t sb[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    // Monitor: every write pulse must match the oldest expected write
    always @(negedge clk_i) begin
        wr_t e;
        if (wb_en_o === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got r%0d=%h, required no write", wb_addr_o, wb_data_o);
            end else begin
                e = sb.pop_front();
                if (wb_addr_o !== e.addr || wb_data_o !== e.data) begin
                    n_fail++;
                    $display("FAIL write: got r%0d=%h, required r%0d=%h", wb_addr_o, wb_data_o, e.addr, e.data);
                end
                n_checks++;
                if (flush_o !== (e.addr == 4'd15)) begin
                    n_fail++;
                    $display("FAIL flush_o on write r%0d: got %b, required %b", e.addr, flush_o, e.addr == 4'd15);
                end
            end
        end else begin
            n_checks++;
            if (flush_o !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_o idle: got %b, required 0", flush_o);
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [3:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        sb.push_back(w);
    endtask

    // Present one instruction for a single edge
    task automatic issue(input logic [31:0] inst, input logic [31:0] pc,
                         input logic [31:0] alu, input logic cond, input logic fl);
        valid_i      = 1'b1;
        cond_pass_i  = cond;
        flush_i      = fl;
        inst_i       = inst;
        pc_i         = pc;
        alu_result_i = alu;
        step();
        valid_i     = 1'b0;
        flush_i     = 1'b0;
        cond_pass_i = 1'b1;
    endtask

    task automatic check_stall(input string name, input logic exp);
        n_checks++;
        if (stall_o !== exp) begin
            n_fail++;
            $display("FAIL %s: stall_o got %b, required %b", name, stall_o, exp);
        end
    endtask

    task automatic check_drained(input string name);
        step();
        step();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d expected writes never appeared", name, sb.size());
        end
        sb.delete();
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        #12;
        n_checks++;
        if ({stall_o, wb_en_o, wb_addr_o, wb_data_o, flush_o} !== 39'd0) begin
            n_fail++;
            $display("FAIL reset_values: got stall=%b en=%b addr=%h data=%h flush=%b, required all 0",
                     stall_o, wb_en_o, wb_addr_o, wb_data_o, flush_o);
        end
`ifdef WB_PERF_EN
        n_checks++;
        if (retired_cnt_o !== 32'd0 || load_stall_cnt_o !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_counters: got %0d/%0d, required 0/0", retired_cnt_o, load_stall_cnt_o);
        end
`endif
        step();
        reset_n_i = 1'b1;
        step();
    endtask

    task automatic test_alu();
        push(4'd3, 32'h0000_0010);
        issue(32'hE080_3000, 32'h0, 32'h0000_0010, 1'b1, 1'b0);  // ADD r3
        step();
        n_checks++;
        if (wb_en_o !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_one_cycle: wb_en_o got %b, required 0", wb_en_o);
        end
        // Opcode boundaries around the compare range: 0111 and 1100 write
        push(4'd1, 32'h1111_0007);
        issue(32'hE0E0_1000, 32'h0, 32'h1111_0007, 1'b1, 1'b0);  // RSC r1
        push(4'd1, 32'h1111_000C);
        issue(32'hE180_1000, 32'h0, 32'h1111_000C, 1'b1, 1'b0);  // ORR r1
        check_drained("alu");
    endtask

    task automatic test_no_write();
        issue(32'hE150_3000, 32'h0, 32'hAAAA_0001, 1'b1, 1'b0);  // CMP
        issue(32'hE111_3000, 32'h0, 32'hAAAA_0002, 1'b1, 1'b0);  // TST
        issue(32'hE113_3000, 32'h0, 32'hAAAA_0003, 1'b1, 1'b0);  // TEQ
        issue(32'hE117_3000, 32'h0, 32'hAAAA_0004, 1'b1, 1'b0);  // CMN
        issue(32'hE080_3000, 32'h0, 32'hAAAA_0005, 1'b0, 1'b0);  // ADD, cond fail
        issue(32'hE080_3000, 32'h0, 32'hAAAA_0006, 1'b1, 1'b1);  // ADD, flushed
        issue(32'hEA00_0000, 32'h100, 32'h0, 1'b1, 1'b0);         // B
        issue(32'hE600_0010, 32'h0, 32'hAAAA_0007, 1'b1, 1'b0);  // class 011
        issue(32'hE890_0000, 32'h0, 32'hAAAA_0008, 1'b1, 1'b0);  // class 100
        issue(32'hE590_5000, 32'h0, 32'hAAAA_0009, 1'b1, 1'b1);  // flushed LDR
        check_stall("flushed_load_no_stall", 1'b0);
        check_drained("no_write");
    endtask

    task automatic test_load_wb();
        push(4'd2, 32'h0000_0100);
        push(4'd5, 32'hDEAD_BEEF);
        issue(32'hE5B2_5000, 32'h0, 32'h0000_0100, 1'b1, 1'b0);  // LDR r5,[r2]!
        check_stall("load_wait_c1", 1'b1);
        // Competing ADD with flush_i during the stall must not disturb the load
        valid_i = 1'b1; flush_i = 1'b1; inst_i = 32'hE080_7000; alu_result_i = 32'h7777_7777;
        step();
        check_stall("load_wait_c2", 1'b1);
        valid_i = 1'b0; flush_i = 1'b0;
        step();
        check_stall("load_wait_c3", 1'b1);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hDEAD_BEEF;
        step();
        mem_rvalid_i = 1'b0;
        check_stall("load_done", 1'b0);
        // Store with writeback: base only; rvalid in RUN is ignored
        push(4'd7, 32'h0000_0208);
        mem_rvalid_i = 1'b1;
        issue(32'hE5A7_1000, 32'h0, 32'h0000_0208, 1'b1, 1'b0);  // STR r1,[r7]!
        mem_rvalid_i = 1'b0;
        check_stall("store_no_stall", 1'b0);
        // rd == rn: base first, load value last
        push(4'd4, 32'h0000_0300);
        push(4'd4, 32'hCAFE_F00D);
        issue(32'hE5B4_4000, 32'h0, 32'h0000_0300, 1'b1, 1'b0);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hCAFE_F00D;
        step();
        mem_rvalid_i = 1'b0;
        check_drained("load_wb");
    endtask

    task automatic test_branch_link();
        push(4'd14, 32'h0000_0000);
        issue(32'hEB00_0000, 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b0);  // BL
        push(4'd15, 32'h0000_0040);
        issue(32'hE3A0_F040, 32'h0, 32'h0000_0040, 1'b1, 1'b0);  // MOV pc,#0x40
        n_checks++;
        if (flush_o !== 1'b1 || wb_data_o !== 32'h40) begin
            n_fail++;
            $display("FAIL pc_redirect: flush_o=%b data=%h, required 1 / 00000040", flush_o, wb_data_o);
        end
        push(4'd14, 32'h0000_1004);
        issue(32'hEB00_0010, 32'h0000_1000, 32'h0, 1'b1, 1'b0);
        check_drained("branch_link");
    endtask

    task automatic test_back_to_back();
        push(4'd5, 32'h5555_0001);
        issue(32'hE592_5000, 32'h0, 32'h0000_0400, 1'b1, 1'b0);  // LDR r5 no W
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5555_0001;
        valid_i = 1'b1; inst_i = 32'hE080_6000; alu_result_i = 32'h6666_0002;
        step();
        mem_rvalid_i = 1'b0;
        check_stall("exit_cycle_accepts", 1'b0);
        push(4'd6, 32'h6666_0002);
        step();
        valid_i = 1'b0;
        push(4'd1, 32'h0000_00A1);
        issue(32'hE080_1000, 32'h0, 32'h0000_00A1, 1'b1, 1'b0);
        push(4'd2, 32'h0000_00A2);
        issue(32'hE080_2000, 32'h0, 32'h0000_00A2, 1'b1, 1'b0);
        push(4'd15, 32'h0000_0080);
        issue(32'hE080_F000, 32'h0, 32'h0000_0080, 1'b1, 1'b0);
        check_drained("back_to_back");
    endtask

    task automatic test_reset_in_load();
        issue(32'hE592_5000, 32'h0, 32'h0000_0200, 1'b1, 1'b0);
        check_stall("pre_reset_wait", 1'b1);
        #2 reset_n_i = 1'b0;
        #1;
        check_stall("async_reset_clears_stall", 1'b0);
        #1 reset_n_i = 1'b1;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD0_BAD0;
        step();
        step();
        mem_rvalid_i = 1'b0;
        check_stall("after_reset", 1'b0);
        check_drained("reset_in_load");
    endtask

`ifdef WB_PERF_EN
    task automatic test_perf();
        logic [31:0] r0, s0;
        r0 = retired_cnt_o;
        s0 = load_stall_cnt_o;
        for (int i = 0; i < 4; i++) begin
            push(4'(i + 8), 32'(i + 100));
            issue(32'hE080_0000 | (32'(i + 8) << 12), 32'h0, 32'(i + 100), 1'b1, 1'b0);
        end
        push(4'd9, 32'h9999_0000);
        issue(32'hE592_9000, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h9999_0000;
        step();
        mem_rvalid_i = 1'b0;
        step();
        n_checks++;
        if (retired_cnt_o - r0 !== 32'd5 || load_stall_cnt_o - s0 !== 32'd2) begin
            n_fail++;
            $display("FAIL perf_counters: retired +%0d stall +%0d, required +5 +2",
                     retired_cnt_o - r0, load_stall_cnt_o - s0);
        end
        check_drained("perf");
    endtask
`endif

    initial begin
        valid_i = 1'b0; cond_pass_i = 1'b1; flush_i = 1'b0;
        inst_i = '0; pc_i = '0; alu_result_i = '0;
        mem_rdata_i = '0; mem_rvalid_i = 1'b0;
        test_reset();
        test_alu();
        test_no_write();
        test_load_wb();
        test_branch_link();
        test_back_to_back();
        test_reset_in_load();
`ifdef WB_PERF_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
